// File: rtl/copy_n.sv
// copy_n: N-way masked fork stage with an input FIFO and eager per-output completion.
// Optional stall watchdog enabled by defining COPYN_WATCHDOG_EN.
module copy_n #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned N       = 3,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   input  logic [N-1:0]                 in_mask,
   output logic [N-1:0]                 out_valid,
   input  logic [N-1:0]                 out_ready,
   output logic [N*WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         stall_err,
   output logic [N-1:0]                 stall_mask
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned EW = WIDTH + N;

   logic [EW-1:0]    mem [DEPTH];
   logic [PW-1:0]    rdPtr;
   logic [PW-1:0]    wrPtr;
   logic [N-1:0]     served;
   logic [WIDTH-1:0] headData;
   logic [N-1:0]     headMask;
   logic [N-1:0]     fire;
   logic             empty;
   logic             push;
   logic             pop;

   // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Head decode, per-output handshake and pop decision from registered state.
   always_comb begin
      headData  = mem[rdPtr][WIDTH-1:0];
      headMask  = mem[rdPtr][EW-1:WIDTH];
      empty     = (level == '0);
      in_ready  = (level != LW'(DEPTH));
      out_valid = {N{!empty}} & headMask & ~served;
      fire      = out_valid & out_ready;
      pop       = !empty && (&(~headMask | served | fire));
      push      = in_valid && in_ready;
      out_data  = {N{headData}};
   end

   // FIFO storage, pointers, occupancy and per-token served tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdPtr  <= '0;
         wrPtr  <= '0;
         level  <= '0;
         served <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wrPtr] <= {in_mask, in_data};
            wrPtr      <= nextPtr(wrPtr);
         end
         if (pop) begin
            rdPtr <= nextPtr(rdPtr);
         end
         if (push && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !push) begin
            level <= level - LW'(1);
         end
         served <= pop ? '0 : (served | fire);
      end
   end

`ifdef COPYN_WATCHDOG_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wdCnt;

   // Count cycles the head sits unpopped; flag once, latching the outstanding outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdCnt      <= '0;
         stall_err  <= 1'b0;
         stall_mask <= '0;
      end else if (empty || pop) begin
         wdCnt <= '0;
      end else begin
         if (wdCnt != CW'(TIMEOUT)) begin
            wdCnt <= wdCnt + CW'(1);
         end
         if ((wdCnt == CW'(TIMEOUT - 1)) && !stall_err) begin
            stall_err  <= 1'b1;
            stall_mask <= headMask & ~served;
         end
      end
   end
`else
   logic unusedWd;

   // Watchdog absent: flags tied low, ports kept.
   assign stall_err  = 1'b0;
   assign stall_mask = '0;
   assign unusedWd   = (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_copy_n.sv
// tb_copy_n: directed self-checking bench for copy_n (N=3, DEPTH=4, TIMEOUT=16).
module tb_copy_n;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned N       = 3;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 16;

`ifdef COPYN_WATCHDOG_EN
   localparam logic       WD_ERR  = 1'b1;
   localparam logic [2:0] WD_MASK = 3'b010;
`else
   localparam logic       WD_ERR  = 1'b0;
   localparam logic [2:0] WD_MASK = 3'b000;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic [N-1:0]         in_mask;
   logic [N-1:0]         out_valid;
   logic [N-1:0]         out_ready;
   logic [N*WIDTH-1:0]   out_data;
   logic [2:0]           level;
   logic                 stall_err;
   logic [N-1:0]         stall_mask;

   int total = 0;
   int bad   = 0;

   copy_n #(.WIDTH(WIDTH), .N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_mask    (in_mask),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .level      (level),
      .stall_err  (stall_err),
      .stall_mask (stall_mask)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL run_timeout: got=stuck exp=finish");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mask   = '0;
      out_ready = '0;
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_stall_err", 64'(stall_err), 64'd0);
      check("rst_stall_mask", 64'(stall_mask), 64'd0);
      reset = 1'b0;
      tick();

      // All ready, broadcast one token.
      out_ready = 3'b111;
      in_valid = 1'b1; in_data = 8'h05; in_mask = 3'b111;
      tick();
      in_valid = 1'b0;
      #1;
      check("bc_valid", 64'(out_valid), 64'h7);
      check("bc_data", 64'(out_data), 64'h050505);
      check("bc_level", 64'(level), 64'd1);
      tick();
      check("bc_pop_level", 64'(level), 64'd0);
      check("bc_pop_valid", 64'(out_valid), 64'd0);

      // Slow output 2: outputs 0 and 1 complete eagerly.
      out_ready = 3'b011;
      in_valid = 1'b1; in_data = 8'hA1; in_mask = 3'b111;
      tick();
      in_valid = 1'b0;
      #1;
      check("slow_valid0", 64'(out_valid), 64'h7);
      tick();
      check("slow_valid1", 64'(out_valid), 64'h4);
      check("slow_level1", 64'(level), 64'd1);
      check("slow_data1", 64'(out_data), 64'hA1A1A1);
      tick();
      check("slow_valid2", 64'(out_valid), 64'h4);
      out_ready = 3'b111;
      tick();
      check("slow_pop_level", 64'(level), 64'd0);
      check("slow_pop_valid", 64'(out_valid), 64'd0);

      // Partial mask, then a mask-0 token.
      in_valid = 1'b1; in_data = 8'h3C; in_mask = 3'b010;
      tick();
      in_data = 8'h77; in_mask = 3'b000;
      #1;
      check("mask010_valid", 64'(out_valid), 64'h2);
      check("mask010_data", 64'(out_data), 64'h3C3C3C);
      tick();
      in_valid = 1'b0;
      #1;
      check("mask0_level", 64'(level), 64'd1);
      check("mask0_valid", 64'(out_valid), 64'd0);
      check("mask0_data", 64'(out_data), 64'h777777);
      tick();
      check("mask0_pop", 64'(level), 64'd0);

      // Fill FIFO with outputs blocked; fifth token waits.
      out_ready = 3'b000;
      in_mask = 3'b111;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data = 8'(8'h11 + i);
         tick();
      end
      #1;
      check("full_level", 64'(level), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_head", 64'(out_data), 64'h111111);
      out_ready = 3'b111;
      #1;
      check("full_valid", 64'(out_valid), 64'h7);
      tick();
      check("drain1_level", 64'(level), 64'd3);
      check("drain1_data", 64'(out_data), 64'h121212);
      check("drain1_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      #1;
      check("drain2_level", 64'(level), 64'd3);
      check("drain2_data", 64'(out_data), 64'h131313);
      tick();
      check("drain3_data", 64'(out_data), 64'h141414);
      tick();
      check("drain4_data", 64'(out_data), 64'h151515);
      check("drain4_level", 64'(level), 64'd1);
      tick();
      check("drain5_level", 64'(level), 64'd0);

      // Output 1 stuck: watchdog behaviour.
      out_ready = 3'b101;
      in_valid = 1'b1; in_data = 8'hB0; in_mask = 3'b111;
      tick();
      in_valid = 1'b0;
      repeat (15) tick();
      check("wd_before", 64'(stall_err), 64'd0);
      tick();
      check("wd_err", 64'(stall_err), 64'(WD_ERR));
      check("wd_mask", 64'(stall_mask), 64'(WD_MASK));
      check("wd_valid", 64'(out_valid), 64'h2);
      out_ready = 3'b111;
      tick();
      check("wd_pop_level", 64'(level), 64'd0);
      check("wd_sticky", 64'(stall_err), 64'(WD_ERR));

      // Asynchronous reset mid-stream.
      out_ready = 3'b000;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data = 8'(8'h21 + i);
         tick();
      end
      in_valid = 1'b0;
      #1;
      check("mid_level", 64'(level), 64'd3);
      #1;
      reset = 1'b1;
      #1;
      check("arst_level", 64'(level), 64'd0);
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_stall", 64'(stall_err), 64'd0);
      check("arst_data", 64'(out_data), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      out_ready = 3'b111;
      in_valid = 1'b1; in_data = 8'h42; in_mask = 3'b111;
      tick();
      in_valid = 1'b0;
      #1;
      check("post_valid", 64'(out_valid), 64'h7);
      check("post_data", 64'(out_data), 64'h424242);
      tick();
      check("post_level", 64'(level), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/copy_n.md
# copy_n

Clocked N-way copy (fork) stage with an input FIFO and per-token destination mask. It is the parametrised successor of the fixed three-way copy: any output count, configurable buffering, selective (masked) delivery, and eager completion, so each output finishes independently of the others. It sits between one producer and N consumers on valid/ready links. An optional watchdog flags an output that never accepts, such as a dead or misconnected consumer.

## Interface
Parameters:
- `WIDTH`, 8: data bits per token.
- `N`, 3: number of outputs (≥1).
- `DEPTH`, 4: input FIFO entries (≥1).
- `TIMEOUT`, 256: watchdog limit in cycles (≥1); used only with `COPYN_WATCHDOG_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer has a token.
- `in_ready`  out  1  FIFO can accept.
- `in_data`  in  WIDTH  token data.
- `in_mask`  in  N  destination set; bit i selects output i.
- `out_valid`  out  N  per-output valid.
- `out_ready`  in  N  per-output ready.
- `out_data`  out  N*WIDTH  slice i = `[i*WIDTH +: WIDTH]`; all slices carry the head data.
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `stall_err`  out  1  sticky watchdog flag.
- `stall_mask`  out  N  outputs outstanding when the watchdog fired.

## Operation
- Input FIFO stores {data, mask}.
  - Push occurs when `in_valid & in_ready`.
  - `in_ready = (level != DEPTH)`. There is no same-cycle pop-through when full.
- `served[N]` register marks head-token outputs already delivered.
  - `out_valid[i] = !empty & head_mask[i] & !served[i]`.
  - `fire[i] = out_valid[i] & out_ready[i]`.
- `done = !empty & &(~head_mask | served | fire)`.
  - When `done`: pop the head and set `served <= 0`.
  - Otherwise: `served <= served | fire`.
- Eager fork:
  - A ready output takes the token immediately.
  - A slow output holds only the head token. Outputs already served drop valid for that token.
- Mask 0 token: popped the cycle it reaches the head; no `out_valid` is asserted.
- `out_data` is stable while any `out_valid` bit is high.
  - It changes only on pop.
  - Slices of deasserted outputs hold head data and are don't-care.
- Simultaneous push and pop: `level` is unchanged. The FIFO pointers wrap modulo DEPTH.
- `out_valid` never depends combinationally on `out_ready`. `in_ready` depends only on registered state.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - `in_ready=1`, `out_valid=0`, `level=0`, `served=0`, `stall_err=0`, `stall_mask=0`.
  - `out_data` = 0.
  - FIFO contents are discarded.
- Latency:
  - A token accepted at edge t has `out_valid` high in cycle t+1 (registered FIFO, no bypass).
- Throughput:
  - One token per cycle when every masked output is ready and `DEPTH ≥ 2`.
  - With `DEPTH=1`, one token per 2 cycles.
- Full FIFO: `in_ready` is low until the cycle after a pop.
- Reset mid-operation: all in-flight tokens are lost and outputs drop valid immediately (asynchronous).

## Configuration
- `COPYN_WATCHDOG_EN` defined:
  - A counter clears on every pop or when the FIFO is empty, and increments on each cycle in which the head is present and not popped.
  - On reaching `TIMEOUT`:
    - `stall_err` goes to 1 and stays there until reset.
    - `stall_mask` latches `head_mask & ~served` at that moment and is not re-latched.
  - Data flow is unaffected.
- Undefined:
  - No counter is instantiated.
  - `stall_err` and `stall_mask` are tied to 0.
  - The ports remain present.

## Test plan
- N=3, all ready, push 0x05 mask 3'b111 -> all three `out_valid` high at t+1 with data 0x05; popped the same cycle; `level` returns to 0.
- Hold `out_ready[2]=0`, push 0xA1 mask 111 -> outputs 0 and 1 fire at t+1 and then drop valid; output 2 keeps valid; pop only when `out_ready[2]` rises.
- Push mask 3'b010 data 0x3C then mask 0 data 0x77 -> only `out_valid[1]` is asserted for 0x3C; the 0x77 token pops with no valid on any output.
- DEPTH=4, all `out_ready=0`, push 5 tokens -> `in_ready` low after 4 pushes, `level=4`; release ready -> tokens emerge in order 1..4 and the 5th is accepted.
- Macro on, TIMEOUT=16, `out_ready[1]` stuck 0 (misconnected consumer), mask 111 -> `stall_err=1` after 16 head cycles, `stall_mask=3'b010`; macro off -> `stall_err` stays 0.
- Assert `reset` mid-stream with `level=3` -> `out_valid=0` and `level=0` immediately; the next token pushed after release appears at t+1.
